// File: rtl/duck_round_manager.sv
// Duck Hunt round bookkeeping: launches ducks, counts shots, times flights, keeps hits and BCD score; all outputs registered, no backpressure.
// Define DUCK_PERFECT_BONUS_EN to add a 1000-point bonus when every duck of the game is hit.
module duck_round_manager #(
    parameter int          SHOTS_PER_DUCK  = 3,
    parameter int          DUCKS_PER_ROUND = 10,
    parameter logic [31:0] FLIGHT_CYCLES   = 32'd150_000_000,
    parameter logic [15:0] POINTS_BCD      = 16'h0500
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [1:0]  state,
    input  logic        trigger,
    input  logic        hit,
    output logic        duck_launch,
    output logic        duck_active,
    output logic        duck_hit,
    output logic [1:0]  shots_left,
    output logic [3:0]  duck_num,
    output logic [3:0]  hits,
    output logic [15:0] score,
    output logic        game_over
);

    localparam logic [1:0] SHOTS_INIT = 2'(SHOTS_PER_DUCK);
    localparam logic [3:0] LAST_DUCK  = 4'(DUCKS_PER_ROUND - 1);
    localparam logic [3:0] MAX_HITS   = 4'(DUCKS_PER_ROUND);

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_FLY, S_RESOLVE, S_OVER} st_t;

    st_t         r_st;
    st_t         w_nxt;
    logic        r_trig_q;
    logic [31:0] r_timer;
    logic [1:0]  r_shots;
    logic [3:0]  r_dnum;
    logic [3:0]  r_hits;
    logic [15:0] r_score;
    logic        r_launch;
    logic        r_active;
    logic        r_dhit;
    logic        r_over;

    logic w_start;
    logic w_game;
    logic w_shot;
    logic w_hit_now;
    logic w_timeout;

    // Digit-serial BCD add; any carry out of the top digit pins the result at 9999.
    function automatic logic [15:0] bcd_add_sat(input logic [15:0] a, input logic [15:0] b);
        logic [4:0]  d;
        logic        c;
        logic [15:0] r;
        c = 1'b0;
        r = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            d = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'b0000, c};
            if (d > 5'd9) begin
                d = d + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[i*4 +: 4] = d[3:0];
        end
        return c ? 16'h9999 : r;
    endfunction

    assign w_start   = (state == 2'b00) || (state == 2'b11);
    assign w_game    = (state == 2'b01);
    assign w_shot    = (r_st == S_FLY) && w_game && trigger && !r_trig_q && (r_shots != 2'd0);
    assign w_hit_now = w_shot && hit;
    assign w_timeout = (r_timer == FLIGHT_CYCLES - 32'd1);

    always_ff @(posedge CLK) begin
        if (RESET) r_st <= S_IDLE;
        else       r_st <= w_nxt;
    end

    always_comb begin
        w_nxt = r_st;
        if (w_start) begin
            w_nxt = S_IDLE;
        end else if (w_game) begin
            case (r_st)
                S_IDLE:    w_nxt = S_LAUNCH;
                S_LAUNCH:  w_nxt = S_FLY;
                // A hit on the escape cycle still resolves through the hit path below.
                S_FLY:     if ((w_shot && (hit || r_shots == 2'd1)) || w_timeout) w_nxt = S_RESOLVE;
                S_RESOLVE: w_nxt = (r_dnum == LAST_DUCK) ? S_OVER : S_LAUNCH;
                S_OVER:    w_nxt = S_OVER;
                default:   w_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_trig_q <= 1'b0;
            r_timer  <= 32'd0;
            r_shots  <= 2'd0;
            r_dnum   <= 4'd0;
            r_hits   <= 4'd0;
            r_score  <= 16'h0000;
            r_launch <= 1'b0;
            r_active <= 1'b0;
            r_dhit   <= 1'b0;
            r_over   <= 1'b0;
        end else begin
            r_trig_q <= trigger;
            if (w_start) begin
                r_timer  <= 32'd0;
                r_shots  <= 2'd0;
                r_dnum   <= 4'd0;
                r_hits   <= 4'd0;
                r_score  <= 16'h0000;
                r_launch <= 1'b0;
                r_active <= 1'b0;
                r_dhit   <= 1'b0;
                r_over   <= 1'b0;
            end else if (w_game) begin
                r_launch <= (w_nxt == S_LAUNCH);
                r_active <= (w_nxt == S_FLY);
                r_over   <= (w_nxt == S_OVER);
                r_dhit   <= w_hit_now;
                case (r_st)
                    S_LAUNCH: begin
                        r_shots <= SHOTS_INIT;
                        r_timer <= 32'd0;
                    end
                    S_FLY: begin
                        r_timer <= r_timer + 32'd1;
                        if (w_shot) r_shots <= r_shots - 2'd1;
                        if (w_hit_now) begin
                            if (r_hits < MAX_HITS) r_hits <= r_hits + 4'd1;
                            r_score <= bcd_add_sat(r_score, POINTS_BCD);
                        end
                    end
                    S_RESOLVE: begin
                        if (r_dnum != LAST_DUCK) begin
                            r_dnum <= r_dnum + 4'd1;
                        end
`ifdef DUCK_PERFECT_BONUS_EN
                        else if (r_hits == MAX_HITS) begin
                            r_score <= bcd_add_sat(r_score, 16'h1000);
                        end
`endif
                    end
                    default: ;
                endcase
            end else begin
                // Done: everything holds; only the one-cycle pulses drop.
                r_launch <= 1'b0;
                r_dhit   <= 1'b0;
            end
        end
    end

    assign duck_launch = r_launch;
    assign duck_active = r_active;
    assign duck_hit    = r_dhit;
    assign shots_left  = r_shots;
    assign duck_num    = r_dnum;
    assign hits        = r_hits;
    assign score       = r_score;
    assign game_over   = r_over;

endmodule

// File: tb/tb_duck_round_manager.sv
// Directed plus randomized game sequences against an arithmetic score/hit model for duck_round_manager.
module tb_duck_round_manager;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [1:0]  st;
    logic        trig;
    logic        hit_i;

    logic        a_launch, a_active, a_dhit, a_over;
    logic [1:0]  a_shots;
    logic [3:0]  a_num, a_hits;
    logic [15:0] a_score;
    logic        b_launch, b_active, b_dhit, b_over;
    logic [1:0]  b_shots;
    logic [3:0]  b_num, b_hits;
    logic [15:0] b_score;

    always #5 CLK = ~CLK;

    duck_round_manager #(.SHOTS_PER_DUCK(3), .DUCKS_PER_ROUND(3), .FLIGHT_CYCLES(32'd100), .POINTS_BCD(16'h0500)) dut_a (
        .CLK(CLK), .RESET(RESET), .state(st), .trigger(trig), .hit(hit_i),
        .duck_launch(a_launch), .duck_active(a_active), .duck_hit(a_dhit), .shots_left(a_shots),
        .duck_num(a_num), .hits(a_hits), .score(a_score), .game_over(a_over));

    duck_round_manager #(.SHOTS_PER_DUCK(3), .DUCKS_PER_ROUND(3), .FLIGHT_CYCLES(32'd100), .POINTS_BCD(16'h5000)) dut_b (
        .CLK(CLK), .RESET(RESET), .state(st), .trigger(trig), .hit(hit_i),
        .duck_launch(b_launch), .duck_active(b_active), .duck_hit(b_dhit), .shots_left(b_shots),
        .duck_num(b_num), .hits(b_hits), .score(b_score), .game_over(b_over));

    int n_assert = 0;
    int n_fail   = 0;
    int m_hits;
    int m_bonus;
    int fly;
    int p_miss[3];
    bit p_hit[3];
    int p_gap[3];
    bit p_pre[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic dtick();
        tick();
        if (a_active) fly++;
    endtask

    function automatic int sat(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_a"}, 32'({a_launch, a_active, a_dhit, a_over, a_shots, a_num, a_hits, a_score}), 32'd0);
        chk({tag, "_b"}, 32'({b_launch, b_active, b_dhit, b_over, b_shots, b_num, b_hits, b_score}), 32'd0);
    endtask

    task automatic check_scores(input string tag);
        chk({tag, "_hits_a"}, 32'(a_hits), 32'(m_hits));
        chk({tag, "_hits_b"}, 32'(b_hits), 32'(m_hits));
        chk({tag, "_score_a"}, 32'(a_score), 32'(to_bcd(sat(m_hits * 500 + m_bonus))));
        chk({tag, "_score_b"}, 32'(b_score), 32'(to_bcd(sat(m_hits * 5000 + m_bonus))));
    endtask

    // Entry: LAUNCH sample of duck d. Exit: RESOLVE sample.
    task automatic play_duck(input int d);
        chk("launch_pulse", 32'(a_launch), 32'd1);
        chk("launch_gap_inactive", 32'(a_active), 32'd0);
        chk("launch_num", 32'(a_num), 32'(d));
        if (p_pre[d]) trig = 1'b1;
        tick();
        trig = 1'b0;
        fly = 1;
        chk("fly_active", 32'(a_active), 32'd1);
        chk("shots_init", 32'(a_shots), 32'd3);
        chk("pre_trig_nohit", 32'(a_dhit), 32'd0);
        for (int k = 0; k < p_miss[d]; k++) begin
            repeat (p_gap[d]) dtick();
            trig = 1'b1;
            hit_i = 1'b0;
            dtick();
            trig = 1'b0;
            chk("miss_shots", 32'(a_shots), 32'(2 - k));
            chk("miss_nohit", 32'(a_dhit), 32'd0);
        end
        if (p_miss[d] == 3) begin
            chk("miss_out_resolve", 32'(a_active), 32'd0);
        end else if (p_hit[d]) begin
            repeat (p_gap[d]) dtick();
            trig = 1'b1;
            hit_i = 1'b1;
            dtick();
            trig = 1'b0;
            hit_i = 1'b0;
            m_hits++;
            chk("hit_pulse", 32'(a_dhit), 32'd1);
            chk("hit_inactive", 32'(a_active), 32'd0);
            chk("hit_shots", 32'(a_shots), 32'(2 - p_miss[d]));
            check_scores("hit");
        end else begin
            for (int i = 0; i < 300 && a_active; i++) dtick();
            chk("escape_len", 32'(fly), 32'd100);
            check_scores("escape");
        end
        chk("resolve_gap", 32'({a_active, a_launch, a_over}), 32'd0);
    endtask

    task automatic play_game();
        m_hits = 0;
        m_bonus = 0;
        st = 2'b01;
        tick();
        for (int d = 0; d < 3; d++) begin
            play_duck(d);
            tick();
        end
`ifdef DUCK_PERFECT_BONUS_EN
        if (m_hits == 3) m_bonus = 1000;
`endif
        chk("game_over_rise", 32'(a_over), 32'd1);
        check_scores("final");
        trig = 1'b1;
        hit_i = 1'b1;
        tick();
        trig = 1'b0;
        hit_i = 1'b0;
        tick();
        chk("over_hold", 32'(a_over), 32'd1);
        chk("over_trig_ignored", 32'({a_active, a_dhit}), 32'd0);
        check_scores("over");
        st = 2'b00;
        tick();
        check_zero("after_game");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1;
        st = 2'b00;
        trig = 1'b0;
        hit_i = 1'b0;
        repeat (3) tick();
        check_zero("reset");
        RESET = 1'b0;
        tick();
        check_zero("idle");

        // every duck escapes
        for (int d = 0; d < 3; d++) begin
            p_miss[d] = 0; p_hit[d] = 0; p_gap[d] = 1; p_pre[d] = 0;
        end
        play_game();

        // three misses, a trigger in LAUNCH that must not count, then hits
        p_miss[0] = 3; p_hit[0] = 0; p_gap[0] = 2; p_pre[0] = 0;
        p_miss[1] = 0; p_hit[1] = 1; p_gap[1] = 3; p_pre[1] = 1;
        p_miss[2] = 1; p_hit[2] = 1; p_gap[2] = 1; p_pre[2] = 0;
        play_game();

        // perfect game, last hit lands on the final flight cycle
        for (int d = 0; d < 3; d++) begin
            p_miss[d] = 0; p_hit[d] = 1; p_gap[d] = 2; p_pre[d] = 0;
        end
        p_gap[2] = 99;
        play_game();
        chk("boundary_hit_fly", 32'(fly), 32'd100);

        repeat (3) begin
            for (int d = 0; d < 3; d++) begin
                p_miss[d] = $urandom_range(0, 3);
                p_hit[d]  = (p_miss[d] < 3) ? ($urandom_range(0, 1) == 1) : 1'b0;
                p_gap[d]  = $urandom_range(1, 6);
                p_pre[d]  = ($urandom_range(0, 3) == 0);
            end
            play_game();
        end

        // Start mid-flight after one hit, then restart at duck 0
        m_hits = 0; m_bonus = 0;
        p_miss[0] = 0; p_hit[0] = 1; p_gap[0] = 2; p_pre[0] = 0;
        st = 2'b01;
        tick();
        play_duck(0);
        tick();
        tick();
        repeat (5) tick();
        chk("mid_fly_active", 32'(a_active), 32'd1);
        st = 2'b00;
        tick();
        check_zero("start_mid_fly");
        st = 2'b01;
        tick();
        chk("restart_launch", 32'(a_launch), 32'd1);
        chk("restart_num", 32'(a_num), 32'd0);

        // RESET mid-flight
        tick();
        repeat (3) tick();
        RESET = 1'b1;
        tick();
        check_zero("reset_mid_fly");
        st = 2'b00;
        RESET = 1'b0;
        tick();

        // Done freezes the flight timer and ignores the trigger
        st = 2'b01;
        tick();
        tick();
        fly = 1;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        fly++;
        chk("pre_freeze_shots", 32'(a_shots), 32'd2);
        st = 2'b10;
        tick();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        repeat (3) tick();
        chk("freeze_state", 32'({a_launch, a_active, a_shots, a_num, a_dhit}), 32'({1'b0, 1'b1, 2'd2, 4'd0, 1'b0}));
        st = 2'b01;
        for (int i = 0; i < 300 && a_active; i++) begin
            tick();
            if (a_active) fly++;
        end
        chk("freeze_timer_len", 32'(fly), 32'd100);
        st = 2'b00;
        tick();
        check_zero("final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
